// File: rtl/m68k_bus_target.sv
// 68000 asynchronous-bus responder: word-wide local RAM with byte lanes inside an address window,
// each cycle terminated with DTACK after a programmable number of wait states.
module m68k_bus_target #(
    parameter logic [23:0] BASE_ADDR   = 24'hE90000,
    parameter int          ADDR_BITS   = 6,
    parameter int          WAIT_STATES = 4
) (
    input  logic        SYSCLK,
    input  logic        RESET,
    input  logic [23:1] A_IN,
    input  logic [2:0]  FC_IN,
    input  logic        nAS_IN,
    input  logic        nUDS_IN,
    input  logic        nLDS_IN,
    input  logic        RnW_IN,
    input  logic [15:0] D_IN,
    output logic [15:0] D_OUT,
    output logic        D_OE,
    output logic        nDTACK_OUT,
    output logic        nDTACK_OE,
    output logic [15:0] ACCESS_CNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_WAIT,
        S_ACK,
        S_HOLD,
        S_RELEASE,
        S_IGNORE
    } state_t;

    localparam int DEPTH = 1 << ADDR_BITS;

    state_t state;
    state_t state_nx;

    logic [3:0] strb_p0;
    logic [3:0] strb_p1;
    logic       as;
    logic       uds;
    logic       lds;
    logic       ds;
    logic       rnw;
    logic       hit;
    logic       load;
    logic       fire;

    logic [ADDR_BITS-1:0] idx_lat;
    logic                 rnw_lat;
    logic                 uds_lat;
    logic                 lds_lat;
    logic [7:0]           wait_cnt;

    logic [15:0] mem [DEPTH];

    // Strobe synchronisers: {RnW, nLDS, nUDS, nAS}
    always_ff @(posedge SYSCLK) begin
        strb_p0 <= {RnW_IN, nLDS_IN, nUDS_IN, nAS_IN};
        strb_p1 <= strb_p0;
    end

    assign as  = ~strb_p1[0];
    assign uds = ~strb_p1[1];
    assign lds = ~strb_p1[2];
    assign rnw = strb_p1[3];
    assign ds  = uds | lds;

    // Address and FC are only looked at once AS is seen, so the bus is already stable.
    assign hit = (FC_IN != 3'b111) &&
                 (A_IN[23:ADDR_BITS+1] == BASE_ADDR[23:ADDR_BITS+1]);

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        fire     = 1'b0;
        case (state)
            S_IDLE: begin
                if (as) state_nx = S_DECODE;
            end
            S_DECODE: begin
                if (!as) begin
                    state_nx = S_IDLE;
                end else if (!hit) begin
                    state_nx = S_IGNORE;
                end else if (ds) begin
                    state_nx = S_WAIT;
                    load     = 1'b1;
                end
            end
            S_WAIT: begin
                if (!as) begin
                    state_nx = S_IDLE;
                end else if (wait_cnt == 8'd0) begin
                    state_nx = S_ACK;
                    fire     = ~RESET;
                end
            end
            S_ACK: begin
                state_nx = S_HOLD;
            end
            S_HOLD: begin
                if (!as) state_nx = S_RELEASE;
            end
            S_RELEASE: begin
                state_nx = S_IDLE;
            end
            S_IGNORE: begin
                if (!as) state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Cycle attributes captured when DS is first seen in a hit cycle
    always_ff @(posedge SYSCLK) begin
        if (load) begin
            idx_lat  <= A_IN[ADDR_BITS:1];
            rnw_lat  <= rnw;
            uds_lat  <= uds;
            lds_lat  <= lds;
            wait_cnt <= 8'(WAIT_STATES);
        end else if (state == S_WAIT && wait_cnt != 8'd0) begin
            wait_cnt <= wait_cnt - 8'd1;
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (fire && !rnw_lat) begin
            if (uds_lat) mem[idx_lat][15:8] <= D_IN[15:8];
            if (lds_lat) mem[idx_lat][7:0]  <= D_IN[7:0];
        end
    end

    // Bus drivers are registered from the next state so the pins never glitch on decode.
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            D_OE       <= 1'b0;
            nDTACK_OE  <= 1'b0;
            nDTACK_OUT <= 1'b1;
            D_OUT      <= 16'h0000;
            ACCESS_CNT <= 16'h0000;
        end else begin
            D_OE       <= (state_nx == S_ACK || state_nx == S_HOLD) && rnw_lat;
            nDTACK_OE  <= (state_nx == S_ACK || state_nx == S_HOLD || state_nx == S_RELEASE);
            nDTACK_OUT <= !(state_nx == S_ACK || state_nx == S_HOLD);
            if (fire) begin
                ACCESS_CNT <= ACCESS_CNT + 16'd1;
                if (rnw_lat) D_OUT <= mem[idx_lat];
            end
        end
    end

endmodule
